bram_fifo_ctrl: RTL and testbench
=================================

Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the dual-port block RAM model and drives both of its ports.
- Port A is write-only, carrying producer data into the RAM.
- Port B is read-only; the controller prefetches through the RAM's 1-cycle registered read into a 2-entry output buffer.
- Presents valid/ready, first-word-fall-through interfaces on both the producer and consumer sides.

Parameters:
- data_w, 2, data width; must match the attached RAM.
- addr_w, 13, RAM address width; RAM capacity is 2**addr_w entries.

Ports:
- CLK  in  1  single clock; also drives RAM CLKA and CLKB.
- RST  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous clear of all contents.
- WR_VALID  in  1  producer has data.
- WR_READY  out  1  controller can accept data.
- WR_DATA  in  data_w  write data.
- RD_VALID  out  1  RD_DATA holds the head entry.
- RD_READY  in  1  consumer takes the head entry.
- RD_DATA  out  data_w  head entry.
- COUNT  out  addr_w+2  total entries held.
- BRAM_ENA  out  1  RAM port A enable.
- BRAM_WEA  out  1  RAM port A write enable.
- BRAM_ADDRA  out  addr_w  write address.
- BRAM_DIA  out  data_w  write data to RAM.
- BRAM_SSRA  out  1  constant 0.
- BRAM_ENB  out  1  RAM port B enable; constant 1.
- BRAM_WEB  out  1  constant 0.
- BRAM_SSRB  out  1  constant 0.
- BRAM_ADDRB  out  addr_w  read address.
- BRAM_DOB  in  data_w  registered read data, valid one cycle after the address is presented.

Behaviour:
- Interface fixed: one clock CLK; reset RST is asynchronous and active-high.
- State held in registers:
  - wr_ptr, rd_ptr: addr_w bits each, wrap modulo 2**addr_w.
  - mem_cnt: addr_w+1 bits, entries in RAM not yet fetched.
  - inflight: 1 bit, a read was issued last cycle.
  - obuf: 2 entries, with ob_cnt of 0..2.
- Write accept: wr_acc = WR_VALID & WR_READY.
  - WR_READY = !RST & (mem_cnt < 2**addr_w).
  - BRAM_ENA = BRAM_WEA = wr_acc; BRAM_ADDRA = wr_ptr; BRAM_DIA = WR_DATA.
  - On wr_acc, wr_ptr increments.
  - WR_VALID while full is ignored; no write, no pointer move.
- Read issue: rd_iss = (mem_cnt != 0) & (ob_cnt + inflight - pop < 2).
  - pop = RD_VALID & RD_READY.
  - BRAM_ADDRB = rd_ptr.
  - On rd_iss, rd_ptr increments; inflight_next = rd_iss.
- Capture: when inflight = 1, BRAM_DOB is written into the obuf tail at the clock edge.
  - Capture and pop in the same cycle are allowed.
  - The obuf never overflows, guaranteed by the rd_iss condition.
- mem_cnt_next = mem_cnt + wr_acc - rd_iss.
  - Simultaneous write and issue leaves mem_cnt unchanged.
  - rd_iss uses the registered mem_cnt, so a read never targets the slot being written in the same cycle.
- RD_VALID = (ob_cnt != 0); RD_DATA = obuf head.
  - Head order is strictly FIFO.
  - RD_DATA is held stable while RD_VALID & !RD_READY.
- COUNT = mem_cnt + inflight + ob_cnt, registered-source sum. Maximum value is 2**addr_w + 2.
- Latency:
  - Write accepted in cycle N into an empty FIFO gives RD_VALID = 1 in cycle N+3 (issue N+1, RAM register N+1→N+2, capture edge N+2→N+3).
  - Sustained throughput is 1 entry per cycle each way.
- Reset (async): on RST assertion, all of the following clear immediately:
  - pointers, counts, inflight and ob_cnt go to 0;
  - obuf data goes to 0;
  - outputs become RD_VALID = 0, RD_DATA = 0, COUNT = 0, WR_READY = 0, BRAM_ENA = BRAM_WEA = 0, BRAM_ADDRA = BRAM_ADDRB = 0.
  - RAM contents are not cleared and are don't-care after reset.
  - Reset mid-operation discards all entries, including any in-flight read.
- FLUSH: same clear as reset, applied at the next edge.
  - WR_READY stays high during FLUSH, but any write in that cycle is dropped; pointers still reset.
  - A pop in the FLUSH cycle is dropped.
- The RAM's BRAM_DOB is not reset. It is ignored unless inflight = 1.

Decomposition:
- No shared package needed; all widths derive from data_w and addr_w.
- One sub-module, bram_fifo_obuf: 2-entry FWFT buffer with push, data in, pop, valid, data out, and count.
  - Reset and FLUSH clear it.
  - Push and pop in the same cycle are allowed when the count is 1 or 2.

Test Plan:
- Bench uses data_w=8, addr_w=4, and an attached RAM model.
1. Reset then single write 0xA5 in cycle 5 → RD_VALID first high in cycle 8 with RD_DATA=0xA5; COUNT=1 from cycle 6; WR_READY=0 while RST high.
2. Fill with RD_READY=0, writing 0x00..0x11 (18 words) → WR_READY drops after mem_cnt reaches 16 (COUNT=18); next WR_VALID is ignored; draining yields 0x00..0x11 in order.
3. Streaming with WR_VALID=RD_READY=1 for 40 cycles, values 0..39 → output 0..39 in order with no gaps after the 3-cycle fill; pointers wrap twice; COUNT steady at 3.
4. Consumer stall: alternate RD_READY 1/0 under full write rate → RD_DATA held stable on stall cycles; no loss or duplication over 32 words.
5. Mid-stream RST pulse with COUNT=7 and a read in flight → outputs clear asynchronously; after release a write of 0x3C reads back as the first word, with no stale data.
6. FLUSH asserted coincident with a write and a pop → next cycle COUNT=0 and RD_VALID=0; the flushed-cycle write never appears on RD_DATA.

Source files
------------

// File: rtl/bram_fifo_obuf.sv
// Two-entry first-word-fall-through buffer that holds words captured from the
// RAM's registered read port until the consumer takes them.
module bram_fifo_obuf #(
    parameter int data_w = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [data_w-1:0] din,
    input  logic              pop,
    output logic              valid,
    output logic [data_w-1:0] dout,
    output logic [1:0]        count
);

    logic [data_w-1:0] ent0_r, ent1_r, ent0_s, ent1_s;
    logic [1:0]        cnt_r, cnt_s;
    logic              pop_s;

    assign pop_s = pop & (cnt_r != 2'd0);
    assign valid = (cnt_r != 2'd0);
    assign dout  = ent0_r;
    assign count = cnt_r;

    // Next-state for the head/tail slots; ent0 is always the head.
    always_comb begin
        ent0_s = ent0_r;
        ent1_s = ent1_r;
        cnt_s  = cnt_r;
        if (flush) begin
            ent0_s = {data_w{1'b0}};
            ent1_s = {data_w{1'b0}};
            cnt_s  = 2'd0;
        end else begin
            case ({push, pop_s})
                2'b10: begin
                    case (cnt_r)
                        2'd0:    ent0_s = din;
                        2'd1:    ent1_s = din;
                        default: ent1_s = ent1_r;
                    endcase
                    cnt_s = cnt_r + 2'd1;
                end
                2'b01: begin
                    ent0_s = ent1_r;
                    cnt_s  = cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        ent0_s = din;
                    end else begin
                        ent0_s = ent1_r;
                        ent1_s = din;
                    end
                end
                default: cnt_s = cnt_r;
            endcase
        end
    end

    // Buffer state register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_r <= {data_w{1'b0}};
            ent1_r <= {data_w{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            ent0_r <= ent0_s;
            ent1_r <= ent1_s;
            cnt_r  <= cnt_s;
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller driving a dual-port block RAM: port A writes producer data,
// port B prefetches through the 1-cycle registered read into a 2-entry buffer.
module bram_fifo_ctrl #(
    parameter int data_w = 2,
    parameter int addr_w = 13
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [data_w-1:0] WR_DATA,
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic [data_w-1:0] RD_DATA,
    output logic [addr_w+1:0] COUNT,
    output logic              BRAM_ENA,
    output logic              BRAM_WEA,
    output logic [addr_w-1:0] BRAM_ADDRA,
    output logic [data_w-1:0] BRAM_DIA,
    output logic              BRAM_SSRA,
    output logic              BRAM_ENB,
    output logic              BRAM_WEB,
    output logic              BRAM_SSRB,
    output logic [addr_w-1:0] BRAM_ADDRB,
    input  logic [data_w-1:0] BRAM_DOB
);

    logic [addr_w-1:0] wr_ptr_r, rd_ptr_r;
    logic [addr_w:0]   mem_cnt_r, mem_cnt_s;
    logic              inflight_r;
    logic              wr_acc_s, rd_iss_s, pop_s;
    logic [1:0]        ob_cnt_s;
    logic [2:0]        occ_s;

    // The RAM holds exactly 2**addr_w words, so its top count bit means full.
    assign WR_READY = ~RST & ~mem_cnt_r[addr_w];
    assign wr_acc_s = WR_VALID & WR_READY;
    assign pop_s    = RD_VALID & RD_READY;
    assign occ_s    = {1'b0, ob_cnt_s} + {2'b00, inflight_r};
    assign rd_iss_s = (mem_cnt_r != {(addr_w+1){1'b0}}) &
                      (occ_s < (3'd2 + {2'b00, pop_s}));

    assign mem_cnt_s = mem_cnt_r + {{addr_w{1'b0}}, wr_acc_s}
                                 - {{addr_w{1'b0}}, rd_iss_s};

    assign BRAM_ENA   = wr_acc_s;
    assign BRAM_WEA   = wr_acc_s;
    assign BRAM_ADDRA = wr_ptr_r;
    assign BRAM_DIA   = WR_DATA;
    assign BRAM_SSRA  = 1'b0;
    assign BRAM_ENB   = 1'b1;
    assign BRAM_WEB   = 1'b0;
    assign BRAM_SSRB  = 1'b0;
    assign BRAM_ADDRB = rd_ptr_r;

    assign COUNT = {1'b0, mem_cnt_r} + {{(addr_w+1){1'b0}}, inflight_r}
                 + {{addr_w{1'b0}}, ob_cnt_s};

    // Pointer, RAM occupancy and in-flight read tracking.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r   <= {addr_w{1'b0}};
            rd_ptr_r   <= {addr_w{1'b0}};
            mem_cnt_r  <= {(addr_w+1){1'b0}};
            inflight_r <= 1'b0;
        end else if (FLUSH) begin
            wr_ptr_r   <= {addr_w{1'b0}};
            rd_ptr_r   <= {addr_w{1'b0}};
            mem_cnt_r  <= {(addr_w+1){1'b0}};
            inflight_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_r + {{(addr_w-1){1'b0}}, wr_acc_s};
            rd_ptr_r   <= rd_ptr_r + {{(addr_w-1){1'b0}}, rd_iss_s};
            mem_cnt_r  <= mem_cnt_s;
            inflight_r <= rd_iss_s;
        end
    end

    bram_fifo_obuf #(.data_w(data_w)) u_obuf (
        .clk   (CLK),
        .rst   (RST),
        .flush (FLUSH),
        .push  (inflight_r),
        .din   (BRAM_DOB),
        .pop   (pop_s),
        .valid (RD_VALID),
        .dout  (RD_DATA),
        .count (ob_cnt_s)
    );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench: attached RAM model plus a queue-based reference model
// of the FIFO (RAM contents, read in flight, output buffer).
module tb_bram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, flush, wv, wr_ready, rv, rr;
    logic [DW-1:0] wd, rd;
    logic [AW+1:0] count;
    logic          ena, wea, ssra, enb, web, ssrb;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dia, dob;
    logic [DW-1:0] ram [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    byte unsigned ram_q[$];
    byte unsigned fly_q[$];
    byte unsigned ob_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ena && wea) ram[addra] <= dia;
        if (enb) dob <= ram[addrb];
    end

    bram_fifo_ctrl #(.data_w(DW), .addr_w(AW)) dut (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .WR_VALID(wv), .WR_READY(wr_ready), .WR_DATA(wd),
        .RD_VALID(rv), .RD_READY(rr), .RD_DATA(rd), .COUNT(count),
        .BRAM_ENA(ena), .BRAM_WEA(wea), .BRAM_ADDRA(addra), .BRAM_DIA(dia),
        .BRAM_SSRA(ssra), .BRAM_ENB(enb), .BRAM_WEB(web), .BRAM_SSRB(ssrb),
        .BRAM_ADDRB(addrb), .BRAM_DOB(dob)
    );

    function automatic void model_clear();
        ram_q.delete();
        fly_q.delete();
        ob_q.delete();
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        logic          e_ready, e_valid, acc, pop, iss;
        logic [AW+1:0] e_count;
        int            occ;
        wv = w; wd = d; rr = r; flush = f;
        #1;
        e_ready = (ram_q.size() < DEPTH);
        e_valid = (ob_q.size() > 0);
        e_count = AW'(0) + 6'(ram_q.size() + fly_q.size() + ob_q.size());
        checks++;
        if (wr_ready !== e_ready) begin
            errors++; $display("FAIL wr_ready: got %b expected %b at %0t", wr_ready, e_ready, $time);
        end
        checks++;
        if (rv !== e_valid) begin
            errors++; $display("FAIL rd_valid: got %b expected %b at %0t", rv, e_valid, $time);
        end
        checks++;
        if (count !== e_count) begin
            errors++; $display("FAIL count: got %0d expected %0d at %0t", count, e_count, $time);
        end
        if (e_valid) begin
            checks++;
            if (rd !== ob_q[0]) begin
                errors++; $display("FAIL rd_data: got %h expected %h at %0t", rd, ob_q[0], $time);
            end
        end
        acc = w && e_ready;
        pop = r && e_valid;
        occ = ob_q.size() + fly_q.size() - (pop ? 1 : 0);
        iss = (ram_q.size() > 0) && (occ < 2);
        @(posedge clk);
        if (f) begin
            model_clear();
        end else begin
            if (pop) void'(ob_q.pop_front());
            if (fly_q.size() > 0) ob_q.push_back(fly_q.pop_front());
            if (iss) fly_q.push_back(ram_q.pop_front());
            if (acc) ram_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (ram_q.size() + fly_q.size() + ob_q.size() == 0) break;
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (count !== 6'd0) begin
            errors++; $display("FAIL drain_empty: got count %0d expected 0", count);
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if ({rv, rd, count, wr_ready, ena, wea, addra, addrb} !== '0) begin
            errors++;
            $display("FAIL %s: got rv=%b rd=%h count=%0d wr_ready=%b ena=%b wea=%b addra=%0d addrb=%0d expected all 0",
                     name, rv, rd, count, wr_ready, ena, wea, addra, addrb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wv = 1'b1; wd = 8'hFF; rr = 1'b0;
        #1;
        check_cleared("reset_state");
        checks++;
        if (enb !== 1'b1 || web !== 1'b0 || ssra !== 1'b0 || ssrb !== 1'b0) begin
            errors++; $display("FAIL bram_consts: got enb=%b web=%b ssra=%b ssrb=%b expected 1 0 0 0", enb, web, ssra, ssrb);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_single_latency();
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        wv = 1'b0; rr = 1'b0;
        #1;
        checks++;
        if (rv !== 1'b1 || rd !== 8'hA5) begin
            errors++; $display("FAIL latency: got rv=%b rd=%h expected 1 a5 three cycles after write", rv, rd);
        end
        @(negedge clk);
        drain(10);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (count !== 6'd18 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL full: got count=%0d wr_ready=%b expected 18 0", count, wr_ready);
        end
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        drain(40);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
        checks++;
        if (count !== 6'd3) begin
            errors++; $display("FAIL stream_count: got %0d expected 3", count);
        end
        drain(20);
    endtask

    task automatic test_stall();
        int sent = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(sent < 32, 8'($urandom), i[0] == 1'b0, 1'b0);
            if (sent < 32 && ram_q.size() > 0) sent++;
        end
        drain(60);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        wv = 1'b0; rr = 1'b0;
        #1;
        checks++;
        if (count !== 6'd7) begin
            errors++; $display("FAIL pre_reset_count: got %0d expected 7", count);
        end
        #1 rst = 1'b1;
        #1;
        check_cleared("async_reset");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (rd !== 8'h3C || count !== 6'd1) begin
            errors++; $display("FAIL post_reset_head: got rd=%h count=%0d expected 3c 1", rd, count);
        end
        drain(10);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        checks++;
        if (count !== 6'd0 || rv !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got count=%0d rv=%b expected 0 0", count, rv);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h12, 1'b1, 1'b0);
        drain(10);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 60) == 0);
        drain(40);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wv = 1'b0; wd = 8'h00; rr = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_latency();
        test_fill();
        test_stream();
        test_stall();
        test_mid_reset();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
